// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: multi-cycle binary-to-BCD converter using shift-add-3
// (double dabble), one input bit per clock, with valid/ready handshakes.
//
// Parameters:
//   W       binary input width (>= 4)
//   D       number of BCD output digits, 10^D must exceed 2^W
//   SIGNED  1 = in_data is two's complement, 0 = unsigned
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   converter is idle and can accept an operand
//   in_data    binary operand, sampled only on the accept cycle
//   out_valid  result is valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_bcd    packed BCD result, digit 0 (units) in [3:0]
//   out_neg    result is negative (never set for zero or when SIGNED=0)
//   out_ndig   number of significant digits, 1..D (zero reports 1)
module seq_bin2bcd #(
  parameter int W      = 18,
  parameter int D      = 6,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*D-1:0]         out_bcd,
  output logic                   out_neg,
  output logic [$clog2(D+1)-1:0] out_ndig
);

  localparam int NDW = $clog2(D+1);
  localparam int CW  = $clog2(W+1);

  // True when D decimal digits can hold every W-bit magnitude.
  function automatic bit digits_fit();
    longint unsigned p10;
    p10 = 64'd1;
    for (int i = 0; i < D; i++) p10 = p10 * 64'd10;
    return p10 > (64'd1 << W);
  endfunction

  generate
    if (W < 4 || !digits_fit()) begin : g_bad_params
      $error("seq_bin2bcd: need W >= 4 and 10^D > 2^W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [4*D-1:0]  acc;
  logic [4*D-1:0]  acc_adj;
  logic [4*D-1:0]  acc_shifted;
  logic [W-1:0]    mag;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            in_neg;
  logic [W-1:0]    in_mag;
  logic [NDW-1:0]  ndig_next;

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand conditioning: the most negative value wraps to 2^(W-1),
  // which is exactly its magnitude as an unsigned W-bit number.
  always_comb begin
    in_neg = (SIGNED != 0) && in_data[W-1];
    in_mag = in_neg ? (~in_data + 1'b1) : in_data;
  end

  // One double-dabble step: add 3 to every digit >= 5 (no carry between
  // digits), then shift in the next magnitude bit. The significant-digit
  // count is taken from the post-shift value so it can be registered on
  // the same edge that enters DONE.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < D; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_shifted = {acc_adj[4*D-2:0], mag[W-1]};
    ndig_next = NDW'(1);
    for (int i = 0; i < D; i++) begin
      if (acc_shifted[4*i +: 4] != 4'd0) ndig_next = NDW'(i + 1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept in IDLE, W shift cycles, wait for the
  // consumer in DONE. in_valid is not looked at outside IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)          state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1))     state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Datapath and registered results. Results are only written on the
  // last shift, so nothing partial ever reaches the outputs, and they
  // hold through DONE and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mag      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      out_bcd  <= '0;
      out_neg  <= 1'b0;
      out_ndig <= NDW'(1);
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= '0;
            mag <= in_mag;
            neg <= in_neg && (in_mag != '0);
            cnt <= CW'(W);
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          mag <= {mag[W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_bcd  <= acc_shifted;
            out_neg  <= neg;
            out_ndig <= ndig_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
Multi-cycle, handshaked binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock. It is the parametrised successor to the team's combinational converter and trades latency for area on wide inputs. Optional signed mode outputs sign plus magnitude, and a significant-digit count for display blanking. It sits between arithmetic datapaths and 7-segment/display drivers.

Parameters:
W, 18, binary input width (W >= 4).
D, 6, BCD output digits; must satisfy 10^D > 2^W (W=18 -> 6); elaboration error otherwise.
SIGNED, 0, 1 = input is two's complement; 0 = unsigned.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  converter can accept
in_data  in  W  binary value
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_bcd  out  4*D  packed BCD, digit 0 (units) in [3:0]
out_neg  out  1  result negative (always 0 when SIGNED=0)
out_ndig  out  $clog2(D+1)  significant digits, 1..D (value 0 reports 1)

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out_bcd=0; out_neg=0; out_ndig=1; internal shift register and counter = 0. Release is synchronous to clk.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Outputs are registered.
- IDLE: on in_valid && in_ready, capture the operand.
  - SIGNED=1 and in_data[W-1]=1: magnitude = -in_data as W-bit unsigned, so -2^(W-1) maps to 2^(W-1); neg=1.
  - Otherwise magnitude = in_data; neg=0.
  - Clear BCD accumulator; counter = W; go to SHIFT.
- SHIFT, each cycle:
  - First, every BCD digit >= 5 gets +3 (4-bit, no carry out of the digit).
  - Then shift {accumulator, magnitude} left by 1 and decrement counter.
  - After the W-th iteration go to DONE.
  - in_valid is ignored throughout SHIFT.
- Latency: out_valid rises exactly W clocks after the accept edge (W=18 -> 18).
- DONE:
  - out_bcd, out_neg and out_ndig are stable while out_valid=1 && out_ready=0.
  - out_ndig = index of the highest nonzero digit + 1, or 1 if all digits are zero. It is computed combinationally from the accumulator and registered on entry to DONE.
  - On out_ready=1: go to IDLE. out_valid drops next cycle; out_bcd, out_neg and out_ndig hold their last values.
- Throughput: at most one conversion per W+2 cycles (accept, W shifts, DONE handshake, IDLE).
- No negative zero: neg is forced to 0 when the magnitude is 0.
- Reset mid-SHIFT or mid-DONE: the conversion is aborted and the reset values above are restored immediately. No partial result is ever presented.
- in_data must be held only on the accept cycle; it is not sampled afterwards.
- Digits above the algorithmic width are always 0 when D exceeds the minimum.

Test Plan:
- Unsigned, W=18, D=6: in_data=0 -> out_bcd=0x000000, out_ndig=1, out_neg=0; out_valid exactly 18 cycles after accept.
- Unsigned max: in_data=262143 -> out_bcd=0x262143, out_ndig=6. Also 99999 -> 0x099999, ndig=5; 1000 -> 0x001000, ndig=4.
- SIGNED=1, W=18: in_data=0x20000 (-131072) -> out_bcd=0x131072, out_neg=1. 0x3FFFF (-1) -> 0x000001, neg=1. 0x1FFFF -> 0x131071, neg=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_bcd stable, in_ready=0, new in_valid pulses ignored. Release -> in_ready=1 the following cycle.
- Reset mid-op: assert rst_n=0 asynchronously at shift 9 -> out_valid=0, in_ready=1 without a clock edge. Next accept of 12345 -> 0x012345 with correct latency.
- Randomised back-to-back: 10k random values with out_ready held high, compared against a golden divide-by-10 model. Must see one conversion per W+2 cycles and no drops.
